direction_input: RTL and testbench
==================================

# direction_input

Front-end stage that feeds the `direction` port of the 2048 game core. It turns four raw push-button inputs into one clean, one-hot move request: it synchronises and debounces each button, detects presses, and arbitrates between them. The request is held stable until the game FSM shows it has consumed it (`game_state` leaves `2'b01`). It sits between the board's key pins and `game2048`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles a request is held in HOLD without being consumed.
- `BTN_ACTIVE_LOW`, default 1: 1 = raw buttons read 0 when pressed.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  4  raw asynchronous buttons; bit0 top, bit1 bottom, bit2 left, bit3 right.
- `game_state`  in  2  from game core: 00 not_playing, 01 playing, 10 win, 11 lose.
- `direction`  out  4  one-hot move request, same bit mapping as `btn`; 0 = no request.
- `pressed`  out  4  debounced pressed level per button (active-high), for LEDs.
- `busy`  out  1  high while a request is outstanding (HOLD or WAIT_IDLE).
- `timeout_err`  out  1  one-cycle pulse when a held request is dropped by timeout.

## Operation
- Per bit, a 2-flop synchroniser on `btn`. Its output is inverted when `BTN_ACTIVE_LOW`=1, giving an active-high `sync[i]`.
- Debounce, per bit: counter width $clog2(DEBOUNCE_CYCLES+1).
  - The counter clears on any cycle where `sync[i]` == `pressed[i]`.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, `pressed[i]` toggles and the counter clears.
- Press event: a 0→1 transition of `pressed[i]`. Releases generate no event. A held button never repeats.
- Arbitration when several events occur in the same cycle: lowest index wins (top > bottom > left > right). The others are discarded, not queued.
- FSM, 3 states:
  - READY: `direction`=0, `busy`=0.
    - A press event with `game_state`==01 goes to HOLD and loads `direction` with the winning one-hot.
    - A press event with any other `game_state` is ignored.
  - HOLD: `direction` is held constant; `busy`=1; timeout counter runs, width $clog2(TIMEOUT_CYCLES+1).
    - If `game_state` != 01 → WAIT_IDLE, `direction` cleared.
    - Else, if the timeout counter reaches TIMEOUT_CYCLES-1 → READY, `direction` cleared, `timeout_err` pulsed.
    - The consume check has priority over timeout in the same cycle.
  - WAIT_IDLE: `direction`=0, `busy`=1. When `game_state`==01 → READY. This state blocks a second move while the core runs MOVE_MERGE / NEW_TILE / CHECK_*.
- Press events arriving in HOLD or WAIT_IDLE are discarded.
- In win/lose the core never returns to 01, so the block stays in WAIT_IDLE until reset. This is intended.
- All outputs are registered.

## Timing
- Reset (async assert, synchronous deassert assumed upstream):
  - Outputs: `direction`=0, `pressed`=0, `busy`=0, `timeout_err`=0.
  - State: FSM=READY; synchronisers reset to the released level; all counters 0.
- Latency: a raw press stable from cycle t gives `sync` at t+2 and `pressed` rising at t+2+DEBOUNCE_CYCLES. `direction` and `busy` assert at t+3+DEBOUNCE_CYCLES.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES consecutive cycles never changes `pressed`.
- Consume: `game_state` first sampled != 01 at edge k → `direction`=0 and state WAIT_IDLE after edge k. `game_state` sampled 01 at edge m → READY after edge m. A new request can load at edge m+1 at the earliest.
- Timeout: `direction` stays high for exactly TIMEOUT_CYCLES cycles, then drops in the same cycle `timeout_err` pulses.
- Reset mid-HOLD: `direction` drops immediately (asynchronous); no `timeout_err` pulse.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16, BTN_ACTIVE_LOW=1.
- Reset release, `btn`=4'b1111, `game_state`=01 → all outputs 0 for 50 cycles.
- Hold `btn[2]` low from cycle t with `game_state`=01 → `direction`=4'b0100 at t+7. Drive `game_state`=00 three cycles later → `direction`=0 next cycle, `busy` stays 1. Return to 01 → `busy`=0 next cycle.
- Bounce `btn[0]` (low 3 cycles, high 1) repeatedly, then hold low → `pressed[0]` rises only after 4 consecutive low samples; exactly one request 4'b0001.
- Press `btn[1]` and `btn[3]` in the same cycle → `direction`=4'b0010 only. Then release and re-press `btn[3]` while in WAIT_IDLE → no request.
- Press with `game_state`=01 and never change it → `direction` high exactly 16 cycles, then 0 together with a single-cycle `timeout_err`.
- Press with `game_state`=11 → `pressed` rises, `direction` stays 0. Assert `rst` low mid-HOLD in a separate run → `direction`=0 asynchronously.

Source files
------------

// File: rtl/direction_input.sv
// Button front-end for the 2048 core: synchronises, debounces and arbitrates four
// push-buttons into a one-hot move request held until the game FSM consumes it.
module direction_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [1:0] game_state,
    output logic [3:0] direction,
    output logic [3:0] pressed,
    output logic       busy,
    output logic       timeout_err
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] RELEASED   = {4{BTN_ACTIVE_LOW}};
    localparam logic [1:0] GS_PLAYING = 2'b01;

    typedef enum logic [1:0] {
        ST_READY     = 2'b00,
        ST_HOLD      = 2'b01,
        ST_WAIT_IDLE = 2'b10
    } state_t;

    logic [3:0]      sync1_r;
    logic [3:0]      sync2_r;
    logic [3:0]      sync_s;
    logic [DB_W-1:0] db_cnt_r [4];
    logic [3:0]      pressed_r;
    logic [3:0]      pressed_d_r;
    logic [3:0]      event_s;
    logic [3:0]      win_s;
    state_t          state_r;
    state_t          state_nxt_s;
    logic [TO_W-1:0] to_cnt_r;
    logic            playing_s;
    logic            to_hit_s;
    logic [3:0]      dir_nxt_s;
    logic            busy_nxt_s;
    logic            terr_nxt_s;
    logic [3:0]      direction_r;
    logic            busy_r;
    logic            timeout_err_r;

    // Two-flop synchroniser; resets to the released level so no press is seen at reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= RELEASED;
            sync2_r <= RELEASED;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    assign sync_s = sync2_r ^ RELEASED;

    // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_r[i] <= DB_ZERO;
            end
            pressed_r   <= 4'b0000;
            pressed_d_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_s[i] == pressed_r[i]) begin
                    db_cnt_r[i] <= DB_ZERO;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_cnt_r[i]  <= DB_ZERO;
                    pressed_r[i] <= ~pressed_r[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
            pressed_d_r <= pressed_r;
        end
    end

    // Rising edges only; the lowest set bit wins and the rest are dropped.
    assign event_s   = pressed_r & ~pressed_d_r;
    assign win_s     = event_s & (~event_s + 4'd1);
    assign playing_s = (game_state == GS_PLAYING);
    assign to_hit_s  = (to_cnt_r == TO_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_READY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; consume takes priority over timeout in HOLD.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_READY: begin
                if (playing_s && (event_s != 4'b0000)) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_HOLD: begin
                if (!playing_s) begin
                    state_nxt_s = ST_WAIT_IDLE;
                end else if (to_hit_s) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_WAIT_IDLE: begin
                if (playing_s) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_WAIT_IDLE;
                end
            end
            default: state_nxt_s = ST_READY;
        endcase
    end

    // Next output values, registered below so every output comes straight from a flop.
    always_comb begin
        dir_nxt_s  = 4'b0000;
        terr_nxt_s = 1'b0;
        case (state_r)
            ST_READY: begin
                if (playing_s && (event_s != 4'b0000)) begin
                    dir_nxt_s = win_s;
                end else begin
                    dir_nxt_s = 4'b0000;
                end
            end
            ST_HOLD: begin
                if (playing_s && !to_hit_s) begin
                    dir_nxt_s = direction_r;
                end else begin
                    dir_nxt_s = 4'b0000;
                end
                terr_nxt_s = playing_s && to_hit_s;
            end
            ST_WAIT_IDLE: dir_nxt_s = 4'b0000;
            default:      dir_nxt_s = 4'b0000;
        endcase
        busy_nxt_s = (state_nxt_s != ST_READY);
    end

    // Hold-time counter runs only while a request is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= TO_ZERO;
        end else if (state_r == ST_HOLD) begin
            to_cnt_r <= to_cnt_r + TO_ONE;
        end else begin
            to_cnt_r <= TO_ZERO;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            direction_r   <= 4'b0000;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            direction_r   <= dir_nxt_s;
            busy_r        <= busy_nxt_s;
            timeout_err_r <= terr_nxt_s;
        end
    end

    assign direction   = direction_r;
    assign pressed     = pressed_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_direction_input.sv
// Self-checking bench for direction_input: directed scenarios plus random button and
// game_state traffic, compared every cycle against a behavioural model.
module tb_direction_input;
    localparam int D = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [1:0] game_state;
    logic [3:0] direction;
    logic [3:0] pressed;
    logic       busy;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    direction_input #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .game_state (game_state),
        .direction  (direction),
        .pressed    (pressed),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: edge-indexed history of synchronised samples, a button
    // toggles once the last D samples since its previous toggle all disagree with it.
    logic [3:0] hraw [0:63];
    logic [3:0] sh   [0:63];
    int         e;
    int         last_tog [4];
    logic [3:0] m_pressed;
    logic [3:0] m_rose;
    logic [3:0] m_dir;
    logic       m_err;
    int         m_mode;     // 0 ready, 1 holding a request, 2 waiting for the core
    int         m_load_e;

    task automatic model_step();
        logic [3:0] s;
        logic [3:0] ev;
        logic [3:0] rose;
        bit         all_diff;
        if (!rst) begin
            e = 0; m_pressed = 4'b0; m_rose = 4'b0; m_dir = 4'b0; m_err = 1'b0; m_mode = 0;
            for (int i = 0; i < 4; i++) last_tog[i] = -1;
            return;
        end
        hraw[e % 64] = btn;
        s = (e >= 2) ? ~hraw[(e - 2) % 64] : 4'b0000;
        sh[e % 64] = s;
        ev   = m_rose;
        rose = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (e - last_tog[i] >= D) begin
                all_diff = 1'b1;
                for (int k = e - D + 1; k <= e; k++)
                    if (sh[k % 64][i] == m_pressed[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_pressed[i] = ~m_pressed[i];
                    last_tog[i]  = e;
                    rose[i]      = m_pressed[i];
                end
            end
        end
        m_err = 1'b0;
        case (m_mode)
            0: if (ev != 4'b0 && game_state == 2'b01) begin
                   m_dir = 4'b0;
                   for (int i = 0; i < 4; i++) if (ev[i] && m_dir == 4'b0) m_dir[i] = 1'b1;
                   m_mode = 1; m_load_e = e;
               end
            1: if (game_state != 2'b01) begin
                   m_mode = 2; m_dir = 4'b0;
               end else if (e - m_load_e == T) begin
                   m_mode = 0; m_dir = 4'b0; m_err = 1'b1;
               end
            2: if (game_state == 2'b01) m_mode = 0;
            default: m_mode = 0;
        endcase
        m_rose = rose;
        e++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare against the model plus request/timeout bookkeeping.
    int         req_count = 0;
    logic [3:0] last_req = 4'b0;
    logic [3:0] dir_prev = 4'b0;
    int         run = 0;
    int         last_run = 0;
    int         err_count = 0;
    int         err_misaligned = 0;

    initial forever begin
        logic [3:0] xd, xp;
        logic       xb, xe;
        @(negedge clk);
        if (!rst) begin
            xd = 4'b0; xp = 4'b0; xb = 1'b0; xe = 1'b0;
        end else begin
            xd = m_dir; xp = m_pressed; xb = (m_mode != 0); xe = m_err;
        end
        check("direction",   32'(direction),   32'(xd));
        check("pressed",     32'(pressed),     32'(xp));
        check("busy",        32'(busy),        32'(xb));
        check("timeout_err", 32'(timeout_err), 32'(xe));
        if (direction != 4'b0 && dir_prev == 4'b0) begin
            req_count++; last_req = direction; run = 0;
        end
        if (direction != 4'b0) run++;
        else if (dir_prev != 4'b0) last_run = run;
        if (timeout_err) begin
            err_count++;
            if (dir_prev == 4'b0 || direction != 4'b0) err_misaligned++;
        end
        dir_prev = direction;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int zc;
        int req0;
        int err0;
        rst = 1'b0; btn = 4'b1111; game_state = 2'b01;
        tick(3);
        at_neg();
        check("reset_outputs", 32'({direction, pressed, busy, timeout_err}), 32'd0);
        tick(1);
        rst = 1'b1;

        // Idle after reset.
        zc = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            at_neg();
            if ({direction, pressed, busy, timeout_err} == 10'd0) zc++;
        end
        check("idle_50_cycles", 32'(zc), 32'd50);

        // btn[2] press, consume and release of WAIT_IDLE.
        tick(1);
        btn = 4'b1011;
        tick(6); at_neg();
        check("left_pressed_t6", 32'(pressed), 32'b0100);
        check("left_dir_t6",     32'(direction), 32'b0000);
        tick(1); at_neg();
        check("left_dir_t7",  32'(direction), 32'b0100);
        check("left_busy_t7", 32'(busy), 32'd1);
        tick(3);
        game_state = 2'b00;
        tick(1); at_neg();
        check("consume_dir",  32'(direction), 32'b0000);
        check("consume_busy", 32'(busy), 32'd1);
        game_state = 2'b01;
        tick(1); at_neg();
        check("wait_release_busy", 32'(busy), 32'd0);
        btn = 4'b1111;
        tick(10);

        // Bouncing btn[0] then a clean hold: one request only.
        req0 = req_count;
        repeat (3) begin
            btn = 4'b1110; tick(3);
            btn = 4'b1111; tick(1);
        end
        at_neg();
        check("bounce_no_press", 32'(pressed[0]), 32'd0);
        btn = 4'b1110;
        tick(12); at_neg();
        check("bounce_req_count", 32'(req_count - req0), 32'd1);
        check("bounce_req_dir",   32'(last_req), 32'b0001);
        game_state = 2'b00; tick(2);
        game_state = 2'b01; tick(1);
        btn = 4'b1111; tick(10);

        // Simultaneous bottom+right; re-press during WAIT_IDLE is dropped.
        btn = 4'b0101;
        tick(7); at_neg();
        check("arb_dir", 32'(direction), 32'b0010);
        req0 = req_count;
        game_state = 2'b00; tick(2);
        btn = 4'b1101; tick(8);
        btn = 4'b0101; tick(10); at_neg();
        check("wait_dir",     32'(direction), 32'b0000);
        check("wait_busy",    32'(busy), 32'd1);
        check("wait_pressed", 32'(pressed), 32'b1010);
        game_state = 2'b01; tick(10); at_neg();
        check("wait_no_request", 32'(req_count - req0), 32'd0);
        btn = 4'b1111; tick(10);

        // Timeout on an unconsumed request.
        err0 = err_count;
        btn = 4'b0111;
        tick(40); at_neg();
        check("timeout_len",     32'(last_run), 32'd16);
        check("timeout_dir",     32'(last_req), 32'b1000);
        check("timeout_pulses",  32'(err_count - err0), 32'd1);
        check("timeout_aligned", 32'(err_misaligned), 32'd0);
        btn = 4'b1111; tick(10);

        // Press while the game is lost: pressed only.
        game_state = 2'b11;
        btn = 4'b1110;
        tick(10); at_neg();
        check("lose_pressed", 32'(pressed[0]), 32'd1);
        check("lose_dir",     32'(direction), 32'b0000);
        btn = 4'b1111; tick(10);

        // Fresh run: asynchronous reset while holding a request.
        rst = 1'b0; tick(3);
        rst = 1'b1; game_state = 2'b01;
        btn = 4'b1101;
        tick(9); at_neg();
        check("hold_before_reset", 32'(direction), 32'b0010);
        err0 = err_count;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("async_reset_dir",  32'(direction), 32'b0000);
        check("async_reset_busy", 32'(busy), 32'd0);
        tick(3);
        rst = 1'b1; btn = 4'b1111;
        tick(5);
        check("reset_no_timeout", 32'(err_count - err0), 32'd0);

        // Random traffic against the model.
        for (int s = 0; s < 200; s++) begin
            btn = 4'($urandom);
            game_state = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
            tick(int'($urandom_range(1, 10)));
        end
        btn = 4'b1111; game_state = 2'b01;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
